// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants for the multi-channel sequence detector.
// Rev 1.0
`default_nettype none

package seq_det_pkg;
  localparam int   PAT_W_MAX = 16;
  localparam logic MODE_OVL  = 1'b1;
  localparam logic MODE_NOVL = 1'b0;
endpackage

`default_nettype wire

// File: rtl/seq_det_lane.sv
// seq_det_lane: one serial channel -- bit history, fill count and match register.
// Rev 1.0
`default_nettype none

module seq_det_lane
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [PAT_W-1:0] pat_q,
  input  logic             overlap,
  input  logic             din,
  input  logic             din_valid,
  output logic             hit,
  output logic             match
);

  localparam int                FILL_W    = $clog2(PAT_W_MAX + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;

  // hit is the next value of match; the top registers its OR alongside
  always_comb begin
    hist_next = {hist[PAT_W-2:0], din};
    fill_next = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    hit       = din_valid && !clr && (fill_next == FILL_FULL) && (hist_next == pat_q);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (din_valid) begin
      hist  <= hist_next;
      fill  <= (hit && (overlap == MODE_NOVL)) ? '0 : fill_next;
      match <= hit;
    end else begin
      match <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_multi.sv
// seq_detect_multi: N-channel programmable pattern detector with OR flag, sticky flag and hit counter.
// Rev 1.0
`default_nettype none

module seq_detect_multi
  import seq_det_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic [N_CH-1:0]  din,
  input  logic [N_CH-1:0]  din_valid,
  input  logic             clr_sticky,
  output logic [N_CH-1:0]  match,
  output logic             any_match,
  output logic             sticky_any,
  output logic [CNT_W-1:0] hit_cnt
);

  logic [PAT_W-1:0] pat_q;
  logic [N_CH-1:0]  hit_vec;
  logic             any_hit;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    seq_det_lane #(
      .PAT_W(PAT_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (cfg_load),
      .pat_q    (pat_q),
      .overlap  (overlap),
      .din      (din[i]),
      .din_valid(din_valid[i]),
      .hit      (hit_vec[i]),
      .match    (match[i])
    );
  end

  assign any_hit = |hit_vec;

  // Set of the sticky flag takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q      <= '0;
      any_match  <= 1'b0;
      sticky_any <= 1'b0;
      hit_cnt    <= '0;
    end else begin
      if (cfg_load) begin
        pat_q <= pat_in;
      end
      any_match <= any_hit;
      if (any_hit) begin
        sticky_any <= 1'b1;
      end else if (clr_sticky) begin
        sticky_any <= 1'b0;
      end
      if (any_hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_multi.md
# seq_detect_multi

Parametrised multi-channel serial sequence detector for the Sequence_Detector design. Watches `N_CH` independent serial bit streams for a run-time programmable `PAT_W`-bit pattern, in overlapping or non-overlapping mode. Produces registered per-channel match pulses, their OR-combined flag, a sticky flag and a saturating hit counter. It is the clocked, width- and channel-generalised successor to the design's 3-input OR combiner: `N_CH`=3 reproduces the three-way OR of match flags.

## Interface
Parameters:
- `N_CH`, 3, number of serial input channels (≥1)
- `PAT_W`, 4, pattern length in bits (2..16)
- `CNT_W`, 8, hit counter width

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cfg_load`  in  1  capture `pat_in` as the new pattern
- `pat_in`  in  `PAT_W`  pattern; bit `PAT_W-1` is the first bit received
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle
- `din`  in  `N_CH`  serial data bit per channel
- `din_valid`  in  `N_CH`  per-channel bit qualifier
- `clr_sticky`  in  1  clears `sticky_any`
- `match`  out  `N_CH`  per-channel one-cycle match pulse
- `any_match`  out  1  OR of all `match` bits, same cycle
- `sticky_any`  out  1  set by any match, held until cleared
- `hit_cnt`  out  `CNT_W`  count of cycles with `any_match`=1, saturating

## Operation
- Pattern register `pat_q` is loaded on `cfg_load`; reset value all zeros.
- Each channel keeps a `PAT_W`-bit history `hist` and a fill counter `fill` (0..`PAT_W`, saturating).
- On a cycle with `din_valid[i]`=1:
  - `hist_next` = {`hist`[PAT_W-2:0], `din[i]`}
  - `fill_next` = min(`fill`+1, `PAT_W`)
- Match condition: `fill_next`==`PAT_W` and `hist_next`==`pat_q`; registers `match[i]`=1 for exactly one cycle.
- After a match:
  - `overlap`=1: `fill` stays at `PAT_W`; the next valid bit may complete a new match.
  - `overlap`=0: `fill` is forced to 0; `PAT_W` fresh bits are needed before the next match.
- A cycle with `din_valid[i]`=0 changes nothing for that channel; `match[i]`=0 that cycle. Gaps do not reset detection.
- `any_match` = OR-reduction of the next `match` vector, registered together with it.
- `sticky_any`: set when `any_match` is being set; cleared by `clr_sticky`. Simultaneous set and clear: set wins.
- `hit_cnt`: +1 per cycle with `any_match`=1, regardless of how many channels matched. Holds at all-ones.
- `cfg_load`: all `hist` and `fill` cleared on the same edge. Any `din_valid` bits that cycle are dropped and `match` is 0 next cycle. `sticky_any` and `hit_cnt` are not affected.
- Reset: `pat_q`, every `hist`/`fill`, `match`, `any_match`, `sticky_any` and `hit_cnt` all go to 0. Reset overrides all other inputs.

## Timing
- Latency: `match[i]` is high in the cycle after the edge that sampled the final pattern bit.
- `any_match` is coincident with `match`. `sticky_any` rises on that same edge. `hit_cnt` increments on that same edge.
- Back-to-back matches, overlap mode: `match[i]` may be high on consecutive cycles, e.g. pattern 1111 with a continuous stream of 1s.
- A new pattern from `cfg_load` applies to the bit sampled on the next edge onward.
- Reset mid-stream: a match whose final bit arrives together with `rst` is lost.
- No combinational path from any input to any output.

## Structure
- Shared package `seq_det_pkg` holds `PAT_W_MAX` and the overlap-mode encoding constants (`MODE_OVL`=1, `MODE_NOVL`=0).
- Sub-module `seq_det_lane`, instantiated `N_CH` times, owns `hist`, `fill` and the per-channel match register. It takes `pat_q`, `overlap` and a clear input.
- The top level owns `pat_q`, the OR-reduction, `sticky_any` and `hit_cnt`.

## Test plan
Defaults throughout: `N_CH`=3, `PAT_W`=4, pattern 1011 loaded.
- Overlap, ch0 stream 1,0,1,1,0,1,1 (valid every cycle) → `match[0]` pulses after bits 4 and 7; `hit_cnt`=2; `sticky_any`=1.
- Non-overlap, same stream → single pulse after bit 4; `hit_cnt`=1.
- ch0 and ch2 complete 1011 on the same edge → `match`=3'b101, `any_match`=1, `hit_cnt` +1 only.
- ch1 stream 1,0,(valid low 3 cycles),1,1 → match after the final 1; gaps are ignored.
- `cfg_load` with `pat_in`=0110 after 3 bits of 1011 are in → no match on the 4th bit; a fresh 0,1,1,0 then matches; `clr_sticky` together with a match leaves `sticky_any`=1.
- `CNT_W`=2, five matches → `hit_cnt` stops at 3. Assert `rst` mid-stream → all outputs 0 on the next cycle and `pat_q`=0000.
